regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Port 0 (pipeline writeback) always wins. Ports 1 (divider) and 2 (load return)
// share the leftover slots round-robin. A busy scoreboard tracks long-latency
// destinations. Starvation counters request a pipeline bubble when a side port
// waits too long.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_we,
    input  logic [4:0]  p_waddr,
    input  logic [31:0] p_wdata,
    input  logic        d_vld,
    input  logic [4:0]  d_waddr,
    input  logic [31:0] d_wdata,
    output logic        d_rdy,
    input  logic        m_vld,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_wdata,
    output logic        m_rdy,
    input  logic        sb_set,
    input  logic [4:0]  sb_addr,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        stall,
    output logic        hold_pipe,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        waw_err
);

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
    // A port is flagged once its counter is about to reach STARVE_MAX, so the
    // flag becomes visible in the same cycle the counter would show STARVE_MAX.
    localparam logic [CNT_W-1:0] STARVE_THR = CNT_W'(STARVE_MAX - 1);

    // Saturating increment for the starvation counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic              rr_last_m;   // 1: port 2 was served last, so port 1 wins a tie
    logic              d_xfer;
    logic              m_xfer;
    logic              gnt_p0;
    logic              we_p0;
    logic [ADDR_W-1:0] waddr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [31:0]       busy;
    logic [31:0]       busy_nxt;
    logic [CNT_W-1:0]  d_cnt;
    logic [CNT_W-1:0]  m_cnt;
    logic              d_hold;
    logic              m_hold;

    // Grant: pipeline first, then the lone requester, then the round-robin pick.
    always_comb begin
        d_rdy = 1'b0;
        m_rdy = 1'b0;
        if (!rst && !p_we) begin
            if (d_vld && (!m_vld || rr_last_m)) begin
                d_rdy = 1'b1;
            end else if (m_vld) begin
                m_rdy = 1'b1;
            end
        end
    end

    assign d_xfer = d_vld & d_rdy;
    assign m_xfer = m_vld & m_rdy;

    // Stage 0: select the granted write; address 0 completes but never writes.
    always_comb begin
        gnt_p0   = p_we | d_xfer | m_xfer;
        waddr_p0 = p_waddr;
        wdata_p0 = p_wdata;
        if (d_xfer) begin
            waddr_p0 = d_waddr;
            wdata_p0 = d_wdata;
        end else if (m_xfer) begin
            waddr_p0 = m_waddr;
            wdata_p0 = m_wdata;
        end
        we_p0 = gnt_p0 && (waddr_p0 != '0);
    end

    // Stage 1: registered regfile write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= we_p0;
            if (gnt_p0) begin
                rf_waddr <= waddr_p0;
                rf_wdata <= wdata_p0;
            end
        end
    end

    // Round-robin pointer moves only when a side port actually transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_m <= 1'b1;
        end else if (d_xfer) begin
            rr_last_m <= 1'b0;
        end else if (m_xfer) begin
            rr_last_m <= 1'b1;
        end
    end

    // Scoreboard next state: side-port writes clear, a new issue sets and wins.
    always_comb begin
        busy_nxt = busy;
        if (d_xfer) busy_nxt[d_waddr] = 1'b0;
        if (m_xfer) busy_nxt[m_waddr] = 1'b0;
        if (sb_set && (sb_addr != '0)) busy_nxt[sb_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign stall = busy[q_addr1] | busy[q_addr2];

    // Starvation counters and per-port bubble requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_cnt  <= '0;
            m_cnt  <= '0;
            d_hold <= 1'b0;
            m_hold <= 1'b0;
        end else begin
            if (!d_vld || d_xfer) begin
                d_cnt  <= '0;
                d_hold <= 1'b0;
            end else begin
                d_cnt <= sat_inc(d_cnt);
                if (d_cnt >= STARVE_THR) d_hold <= 1'b1;
            end
            if (!m_vld || m_xfer) begin
                m_cnt  <= '0;
                m_hold <= 1'b0;
            end else begin
                m_cnt <= sat_inc(m_cnt);
                if (m_cnt >= STARVE_THR) m_hold <= 1'b1;
            end
        end
    end

    assign hold_pipe = d_hold | m_hold;

    // Sticky write-after-write error: the pipeline overwrote a pending destination.
    always_ff @(posedge clk) begin
        if (rst) begin
            waw_err <= 1'b0;
        end else if (p_we && (p_waddr != '0) && busy[p_waddr]) begin
            waw_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: table of arbitration vectors plus
// hand-written sequences for scoreboard, starvation, WAW and reset behaviour.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [31:0] p_wdata;
    logic        d_vld;
    logic [4:0]  d_waddr;
    logic [31:0] d_wdata;
    logic        d_rdy;
    logic        m_vld;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_rdy;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        stall;
    logic        hold_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        waw_err;

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
        .d_vld(d_vld), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_rdy(d_rdy),
        .m_vld(m_vld), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_rdy(m_rdy),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .stall(stall),
        .hold_pipe(hold_pipe),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .waw_err(waw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        p_we;
        logic [4:0]  p_waddr;
        logic [31:0] p_wdata;
        logic        d_vld;
        logic [4:0]  d_waddr;
        logic [31:0] d_wdata;
        logic        m_vld;
        logic [4:0]  m_waddr;
        logic [31:0] m_wdata;
        logic        e_drdy;
        logic        e_mrdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[12];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                                input logic dv, input logic [4:0] da, input logic [31:0] dd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic edr, input logic emr, input logic ew,
                                input logic [4:0] ea, input logic [31:0] ed);
        vec_t v;
        v.p_we = pw; v.p_waddr = pa; v.p_wdata = pd;
        v.d_vld = dv; v.d_waddr = da; v.d_wdata = dd;
        v.m_vld = mv; v.m_waddr = ma; v.m_wdata = md;
        v.e_drdy = edr; v.e_mrdy = emr; v.e_we = ew; v.e_addr = ea; v.e_data = ed;
        return v;
    endfunction

    task automatic expect_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.we = we; w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    // Advance one clock and compare the registered write against the scoreboard.
    task automatic tick(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s scoreboard: no expected write queued", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " rf_we"}, 32'(rf_we), 32'(e.we));
            if (e.we) begin
                chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
                chk({tag, " rf_wdata"}, rf_wdata, e.data);
            end
        end
    endtask

    task automatic idle_inputs();
        p_we = 0; p_waddr = 0; p_wdata = 0;
        d_vld = 0; d_waddr = 0; d_wdata = 0;
        m_vld = 0; m_waddr = 0; m_wdata = 0;
        sb_set = 0; sb_addr = 0; q_addr1 = 0; q_addr2 = 0;
    endtask

    // Pipeline writes every cycle while one side port waits; check bubble request timing.
    task automatic starve(input logic use_m);
        string nm;
        nm = use_m ? "starve_m" : "starve_d";
        for (int c = 1; c <= 6; c++) begin
            p_we = 1; p_waddr = 5'd1; p_wdata = 32'h100 + 32'(c);
            if (use_m) begin
                m_vld = 1; m_waddr = 5'd20; m_wdata = 32'hA0;
            end else begin
                d_vld = 1; d_waddr = 5'd21; d_wdata = 32'hB0;
            end
            #1;
            chk($sformatf("%s hold c%0d", nm, c), 32'(hold_pipe), (c >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("%s rdy c%0d", nm, c), 32'(use_m ? m_rdy : d_rdy), 32'd0);
            expect_wr(1'b1, 5'd1, 32'h100 + 32'(c));
            tick(nm);
        end
        p_we = 0;
        #1;
        chk({nm, " rdy release"}, 32'(use_m ? m_rdy : d_rdy), 32'd1);
        chk({nm, " hold before xfer"}, 32'(hold_pipe), 32'd1);
        if (use_m) expect_wr(1'b1, 5'd20, 32'hA0);
        else       expect_wr(1'b1, 5'd21, 32'hB0);
        tick(nm);
        m_vld = 0; d_vld = 0;
        #1;
        chk({nm, " hold after xfer"}, 32'(hold_pipe), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Arbitration table, applied right after reset (port 1 wins first tie).
        vecs[0]  = mk(0, 0, 0,       1,  9, 32'hD0, 1, 10, 32'hE0, 1, 0, 1,  9, 32'hD0);
        vecs[1]  = mk(0, 0, 0,       1, 11, 32'hD1, 1, 10, 32'hE0, 0, 1, 1, 10, 32'hE0);
        vecs[2]  = mk(0, 0, 0,       1, 11, 32'hD1, 1, 12, 32'hE1, 1, 0, 1, 11, 32'hD1);
        vecs[3]  = mk(1, 3, 32'h11,  1, 13, 32'hD2, 1, 12, 32'hE1, 0, 0, 1,  3, 32'h11);
        vecs[4]  = mk(0, 0, 0,       1, 13, 32'hD2, 1, 12, 32'hE1, 0, 1, 1, 12, 32'hE1);
        vecs[5]  = mk(0, 0, 0,       1, 13, 32'hD2, 0,  0, 0,      1, 0, 1, 13, 32'hD2);
        vecs[6]  = mk(0, 0, 0,       1,  0, 32'hD3, 0,  0, 0,      1, 0, 0,  0, 0);
        vecs[7]  = mk(0, 0, 0,       1, 14, 32'hD4, 1,  0, 32'hE2, 0, 1, 0,  0, 0);
        vecs[8]  = mk(0, 0, 0,       1, 14, 32'hD4, 1, 15, 32'hE3, 1, 0, 1, 14, 32'hD4);
        vecs[9]  = mk(0, 0, 0,       0,  0, 0,      0,  0, 0,      0, 0, 0,  0, 0);
        vecs[10] = mk(1, 0, 32'h99,  1, 15, 32'hD5, 0,  0, 0,      0, 0, 0,  0, 0);
        vecs[11] = mk(0, 0, 0,       1, 15, 32'hD5, 0,  0, 0,      1, 0, 1, 15, 32'hD5);

        // Reset with requests present: no ready, no write.
        idle_inputs();
        rst = 1; p_we = 1; p_waddr = 5'd4; p_wdata = 32'h44; d_vld = 1; m_vld = 1;
        #1;
        chk("rst d_rdy", 32'(d_rdy), 0);
        chk("rst m_rdy", 32'(m_rdy), 0);
        expect_wr(0, 0, 0); tick("rst0");
        expect_wr(0, 0, 0); tick("rst1");
        chk("rst rf_waddr", 32'(rf_waddr), 0);
        chk("rst rf_wdata", rf_wdata, 0);
        chk("rst hold_pipe", 32'(hold_pipe), 0);
        chk("rst waw_err", 32'(waw_err), 0);
        chk("rst stall", 32'(stall), 0);
        rst = 0;
        idle_inputs();

        // Table-driven arbitration vectors.
        for (int i = 0; i < 12; i++) begin
            p_we = vecs[i].p_we; p_waddr = vecs[i].p_waddr; p_wdata = vecs[i].p_wdata;
            d_vld = vecs[i].d_vld; d_waddr = vecs[i].d_waddr; d_wdata = vecs[i].d_wdata;
            m_vld = vecs[i].m_vld; m_waddr = vecs[i].m_waddr; m_wdata = vecs[i].m_wdata;
            #1;
            chk($sformatf("vec%0d d_rdy", i), 32'(d_rdy), 32'(vecs[i].e_drdy));
            chk($sformatf("vec%0d m_rdy", i), 32'(m_rdy), 32'(vecs[i].e_mrdy));
            expect_wr(vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data);
            tick($sformatf("vec%0d", i));
        end
        idle_inputs();

        // Scoreboard: set, query, clear, and same-cycle set+clear.
        sb_set = 1; sb_addr = 5'd5;
        #1;
        chk("sb pre stall", 32'(stall), 0);
        expect_wr(0, 0, 0); tick("sb set");
        sb_set = 0; q_addr1 = 5'd5;
        #1;
        chk("sb stall q1", 32'(stall), 1);
        q_addr1 = 0; q_addr2 = 5'd5;
        #1;
        chk("sb stall q2", 32'(stall), 1);
        expect_wr(0, 0, 0); tick("sb idle");
        q_addr1 = 5'd5; q_addr2 = 0;
        d_vld = 1; d_waddr = 5'd5; d_wdata = 32'h55;
        #1;
        chk("sb d_rdy", 32'(d_rdy), 1);
        expect_wr(1, 5'd5, 32'h55); tick("sb clr");
        d_vld = 0;
        #1;
        chk("sb stall cleared", 32'(stall), 0);
        sb_set = 1; sb_addr = 5'd5;
        expect_wr(0, 0, 0); tick("sb reset5");
        sb_set = 1; sb_addr = 5'd5; d_vld = 1; d_waddr = 5'd5; d_wdata = 32'h56;
        #1;
        chk("sb both d_rdy", 32'(d_rdy), 1);
        expect_wr(1, 5'd5, 32'h56); tick("sb both");
        sb_set = 0; d_vld = 0;
        #1;
        chk("sb set wins", 32'(stall), 1);
        m_vld = 1; m_waddr = 5'd5; m_wdata = 32'h57;
        #1;
        chk("sb m_rdy", 32'(m_rdy), 1);
        expect_wr(1, 5'd5, 32'h57); tick("sb mclr");
        m_vld = 0;
        #1;
        chk("sb m cleared", 32'(stall), 0);
        sb_set = 1; sb_addr = 0; q_addr1 = 0;
        expect_wr(0, 0, 0); tick("sb addr0");
        sb_set = 0;
        #1;
        chk("sb busy0", 32'(stall), 0);
        idle_inputs();

        // WAW: pipeline writes a pending register.
        sb_set = 1; sb_addr = 5'd7;
        expect_wr(0, 0, 0); tick("waw set");
        sb_set = 0; p_we = 1; p_waddr = 5'd7; p_wdata = 32'h77;
        #1;
        chk("waw before", 32'(waw_err), 0);
        expect_wr(1, 5'd7, 32'h77); tick("waw write");
        p_we = 0;
        #1;
        chk("waw set", 32'(waw_err), 1);
        for (int k = 0; k < 3; k++) begin
            expect_wr(0, 0, 0); tick("waw idle");
            chk($sformatf("waw sticky%0d", k), 32'(waw_err), 1);
        end

        // Reset mid-stream with busy bits set and a grant in the reset cycle.
        sb_set = 1; sb_addr = 5'd8;
        expect_wr(0, 0, 0); tick("mid set8");
        sb_addr = 5'd9;
        expect_wr(0, 0, 0); tick("mid set9");
        sb_set = 0; q_addr1 = 5'd8; q_addr2 = 5'd9;
        #1;
        chk("mid stall", 32'(stall), 1);
        rst = 1; p_we = 1; p_waddr = 5'd2; p_wdata = 32'h22;
        d_vld = 1; d_waddr = 5'd3; d_wdata = 32'h33;
        #1;
        chk("mid rst d_rdy", 32'(d_rdy), 0);
        expect_wr(0, 0, 0); tick("mid rst");
        chk("mid rf_waddr", 32'(rf_waddr), 0);
        chk("mid rf_wdata", rf_wdata, 0);
        chk("mid hold_pipe", 32'(hold_pipe), 0);
        chk("mid waw_err", 32'(waw_err), 0);
        chk("mid stall", 32'(stall), 0);
        rst = 0;
        idle_inputs();
        q_addr1 = 5'd8; q_addr2 = 5'd7;
        expect_wr(0, 0, 0); tick("mid post");
        chk("mid stall post", 32'(stall), 0);
        idle_inputs();

        // Starvation of each side port under continuous pipeline writes.
        starve(1'b1);
        starve(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
